// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: native word width and datapath mux select modes.
// Constants only, so there is no latency or backpressure.
package cpu_pkg;
   localparam int   DATA_W      = 24;
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;
endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin grant among CHANNELS requesters, searching upward from ptr with wrap.
// Purely combinational (0 cycles); it has no backpressure of its own.
module rr_arbiter_n #(
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    grant,
   output logic                grant_vld
);

   logic [2*CHANNELS-1:0] req_dbl;
   logic [CHANNELS-1:0]   req_rot;
   int                    off;
   int                    sum;

   // Doubling the vector makes a plain part-select act as a rotate for any CHANNELS.
   assign req_dbl = {req, req};

   always_comb begin
      req_rot   = req_dbl[ptr +: CHANNELS];
      grant_vld = |req_rot;
      off       = 0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (req_rot[i]) off = i;
      end
      sum = int'(ptr) + off;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      grant = SEL_W'(sum);
   end

endmodule

// File: rtl/mux_nto1_reg.sv
// N-to-1 registered mux with direct or round-robin select; 1-cycle latency, 1 word/cycle.
// Backpressure: input ready only while the output register is empty or draining this cycle.
module mux_nto1_reg
   import cpu_pkg::*;
#(
   parameter  int WIDTH    = DATA_W,
   parameter  int CHANNELS = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      Clock,
   input  logic                      ResetN,
   input  logic [CHANNELS*WIDTH-1:0] Hyrja,
   input  logic [CHANNELS-1:0]       HyrjaValid,
   output logic [CHANNELS-1:0]       HyrjaReady,
   input  logic [SEL_W-1:0]          S,
   input  logic                      Mode,
   output logic [WIDTH-1:0]          Dalja,
   output logic                      DaljaValid,
   input  logic                      DaljaReady,
   output logic [SEL_W-1:0]          DaljaKanali
);

   logic             load_ok;
   logic             rr_vld;
   logic             grant_vld;
   logic             sel_vld;
   logic             xfer;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_nxt;
   logic [SEL_W-1:0] rr_grant;
   logic [SEL_W-1:0] grant;
   logic [WIDTH-1:0] sel_dat;

   rr_arbiter_n #(.CHANNELS(CHANNELS)) u_arb (
      .req       (HyrjaValid),
      .ptr       (ptr),
      .grant     (rr_grant),
      .grant_vld (rr_vld)
   );

   // Gating with ResetN keeps producers from seeing a handshake that reset will discard.
   assign load_ok = ResetN && (!DaljaValid || DaljaReady);

   always_comb begin
      if (Mode == MODE_RR) begin
         grant     = rr_grant;
         grant_vld = rr_vld;
      end else begin
         grant     = S;
         grant_vld = (int'(S) < CHANNELS);
      end
   end

   always_comb begin
      HyrjaReady = '0;
      sel_vld    = 1'b0;
      sel_dat    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant_vld && grant == SEL_W'(k)) begin
            HyrjaReady[k] = load_ok;
            sel_vld       = HyrjaValid[k];
            sel_dat       = Hyrja[k*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer    = sel_vld && load_ok;
   assign ptr_nxt = (int'(grant) == CHANNELS - 1) ? '0 : grant + SEL_W'(1);

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         Dalja       <= '0;
         DaljaValid  <= 1'b0;
         DaljaKanali <= '0;
         ptr         <= '0;
      end else if (xfer) begin
         Dalja       <= sel_dat;
         DaljaValid  <= 1'b1;
         DaljaKanali <= grant;
         if (Mode == MODE_RR) ptr <= ptr_nxt;
      end else if (DaljaReady) begin
         DaljaValid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: a 4-channel instance checked against a queue-free reference model
// plus vector tables, and a 3-channel instance exercising the out-of-range select.
module tb_mux_nto1_reg;
   localparam int W   = 24;
   localparam int CH  = 4;
   localparam int CH3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rstn, mode, drdy, dv;
   logic [CH*W-1:0]   hy;
   logic [CH-1:0]     hv, hr;
   logic [1:0]        s, dk;
   logic [W-1:0]      dd;

   logic              rstn3, mode3, drdy3, dv3;
   logic [CH3*W-1:0]  hy3;
   logic [CH3-1:0]    hv3, hr3;
   logic [1:0]        s3, dk3;
   logic [W-1:0]      dd3;

   mux_nto1_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
      .Clock(clk), .ResetN(rstn), .Hyrja(hy), .HyrjaValid(hv), .HyrjaReady(hr),
      .S(s), .Mode(mode), .Dalja(dd), .DaljaValid(dv), .DaljaReady(drdy), .DaljaKanali(dk)
   );

   mux_nto1_reg #(.WIDTH(W), .CHANNELS(CH3)) dut3 (
      .Clock(clk), .ResetN(rstn3), .Hyrja(hy3), .HyrjaValid(hv3), .HyrjaReady(hr3),
      .S(s3), .Mode(mode3), .Dalja(dd3), .DaljaValid(dv3), .DaljaReady(drdy3), .DaljaKanali(dk3)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model of the 4-channel instance: output register contents and rr pointer.
   logic         m_vld = 1'b0;
   logic [W-1:0] m_dat = '0;
   int           m_ch  = 0;
   int           m_ptr = 0;

   function automatic int model_grant();
      if (!rstn) return -1;
      if (m_vld && !drdy) return -1;
      if (mode == 1'b0) return (int'(s) < CH) ? int'(s) : -1;
      for (int i = 0; i < CH; i++) begin
         int k = (m_ptr + i) % CH;
         if (hv[k]) return k;
      end
      return -1;
   endfunction

   task automatic step();
      int            g;
      logic [CH-1:0] er;
      @(negedge clk);
      g  = model_grant();
      er = (g >= 0) ? (CH'(1) << g) : '0;
      chk("hyrja_ready", hr, er);
      @(posedge clk);
      if (!rstn) begin
         m_vld = 1'b0; m_dat = '0; m_ch = 0; m_ptr = 0;
      end else if (g >= 0 && hv[g]) begin
         m_vld = 1'b1; m_dat = hy[g*W +: W]; m_ch = g;
         if (mode) m_ptr = (g + 1) % CH;
      end else if (drdy) begin
         m_vld = 1'b0;
      end
      #1;
      chk("dalja_valid", dv, m_vld);
      chk("dalja", dd, m_dat);
      chk("dalja_kanali", dk, m_ch);
   endtask

   task automatic tick3();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          mode;
      logic [1:0]    s;
      logic [CH-1:0] hv;
      logic [CH*W-1:0] hy;
      logic [CH-1:0] exp_rdy;
      logic [1:0]    exp_k;
      logic [W-1:0]  exp_d;
   } vec_t;

   vec_t vec[8];
   int   sp_exp[3] = '{3, 1, 3};
   localparam logic [CH*W-1:0] DIR_HY = {24'h444444, 24'hABCDEF, 24'h222222, 24'h111111};
   localparam logic [CH*W-1:0] RR_HY  = {24'd4, 24'd3, 24'd2, 24'd1};

   initial begin
      vec[0] = '{1'b0, 2'd2, 4'hF, DIR_HY, 4'b0100, 2'd2, 24'hABCDEF};
      vec[1] = '{1'b0, 2'd2, 4'hF, DIR_HY, 4'b0100, 2'd2, 24'hABCDEF};
      vec[2] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b0001, 2'd0, 24'd1};
      vec[3] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b0010, 2'd1, 24'd2};
      vec[4] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b0100, 2'd2, 24'd3};
      vec[5] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b1000, 2'd3, 24'd4};
      vec[6] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b0001, 2'd0, 24'd1};
      vec[7] = '{1'b1, 2'd0, 4'hF, RR_HY,  4'b0010, 2'd1, 24'd2};

      rstn = 1'b0; mode = 1'b0; s = 2'd0; hv = '1; drdy = 1'b1; hy = RR_HY;
      rstn3 = 1'b0; mode3 = 1'b0; s3 = 2'd0; hv3 = '1; drdy3 = 1'b1;
      hy3 = {24'h000333, 24'h000222, 24'h000111};

      // Reset hold with every channel valid.
      repeat (3) step();
      chk("reset_valid", dv, 1'b0);
      chk("reset_data", dd, '0);

      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mode = vec[i].mode; s = vec[i].s; hv = vec[i].hv; hy = vec[i].hy; drdy = 1'b1;
         #1;
         chk("tbl_ready", hr, vec[i].exp_rdy);
         step();
         chk("tbl_kanali", dk, vec[i].exp_k);
         chk("tbl_dalja", dd, vec[i].exp_d);
         chk("tbl_valid", dv, 1'b1);
      end

      // Back-pressure: hold 0x55 for five cycles while inputs churn.
      mode = 1'b0; s = 2'd0; hv = '1; drdy = 1'b1;
      hy = {24'h000004, 24'h000003, 24'h000002, 24'h000055};
      step();
      chk("bp_load", dd, 24'h000055);
      drdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         hy = {$urandom, $urandom, $urandom};
         hv = 4'($urandom); s = 2'($urandom); mode = 1'($urandom);
         #1;
         chk("bp_ready", hr, '0);
         step();
         chk("bp_hold", dd, 24'h000055);
         chk("bp_valid", dv, 1'b1);
      end
      drdy = 1'b1; mode = 1'b0; s = 2'd1; hv = '1;
      hy = {24'h000004, 24'h000003, 24'h000077, 24'h000001};
      #1;
      chk("drain_load_ready", hr, 4'b0010);
      step();
      chk("drain_load", dd, 24'h000077);
      chk("drain_load_valid", dv, 1'b1);

      // Sparse round-robin starting from ptr=2.
      mode = 1'b1; hv = 4'b1010; hy = RR_HY;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sparse_kanali", dk, sp_exp[i]);
      end
      hv = '1;
      #1;
      chk("ptr_wrapped", hr, 4'b0001);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rstn = ($urandom_range(0, 39) != 0);
         mode = 1'($urandom); s = 2'($urandom); hv = 4'($urandom);
         drdy = ($urandom_range(0, 3) != 0);
         hy = {$urandom, $urandom, $urandom};
         step();
      end

      // Three-channel instance: S=3 has no grant, then reset while holding data.
      repeat (2) tick3();
      chk("c3_reset_valid", dv3, 1'b0);
      chk("c3_reset_ready", hr3, '0);
      rstn3 = 1'b1; s3 = 2'd2;
      #1;
      chk("c3_ready_s2", hr3, 3'b100);
      tick3();
      chk("c3_kanali", dk3, 2'd2);
      chk("c3_dalja", dd3, 24'h000333);
      drdy3 = 1'b0; s3 = 2'd3;
      #1;
      chk("c3_stall_ready", hr3, '0);
      tick3();
      chk("c3_stall_hold", dd3, 24'h000333);
      chk("c3_stall_valid", dv3, 1'b1);
      drdy3 = 1'b1;
      #1;
      chk("c3_bad_sel_ready", hr3, '0);
      tick3();
      chk("c3_bad_sel_no_xfer", dv3, 1'b0);
      mode3 = 1'b1; hv3 = 3'b010;
      #1;
      chk("c3_rr_ready", hr3, 3'b010);
      tick3();
      chk("c3_rr_kanali", dk3, 2'd1);
      chk("c3_rr_valid", dv3, 1'b1);
      hv3 = 3'b111;
      #1;
      chk("c3_ptr_two", hr3, 3'b100);
      rstn3 = 1'b0; drdy3 = 1'b0;
      #1;
      chk("c3_reset_gate", hr3, '0);
      tick3();
      chk("c3_midreset_valid", dv3, 1'b0);
      chk("c3_midreset_data", dd3, '0);
      chk("c3_midreset_kanali", dk3, '0);
      rstn3 = 1'b1; drdy3 = 1'b1;
      #1;
      chk("c3_ptr_reset", hr3, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised N-to-1 registered multiplexer for the 24-bit CPU datapath.
- Successor to the fixed 2:1 4-bit combinational mux. Adds configurable width and channel count, a one-stage output register, and a valid/ready handshake on every channel.
- Two selection modes:
  - direct: the external select input `S` picks the channel.
  - round-robin: the block arbitrates among the valid channels itself.
- Sits between multiple producers (register file read ports, ALU, immediate path) and a single consumer bus.

Parameters:
- WIDTH, 24, data width per channel in bits.
- CHANNELS, 4, number of input channels, legal range 2..16.
- SEL_W, $clog2(CHANNELS), select and channel-id width; derived, never overridden.

Ports:
- Clock  input  1  rising-edge clock.
- ResetN  input  1  synchronous reset, active-low.
- Hyrja  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- HyrjaValid  input  CHANNELS  per-channel valid.
- HyrjaReady  output  CHANNELS  per-channel ready; at most one bit high in any cycle.
- S  input  SEL_W  channel select, used only when Mode=0.
- Mode  input  1  0 = direct select, 1 = round-robin.
- Dalja  output  WIDTH  registered output data.
- DaljaValid  output  1  output register holds valid data.
- DaljaReady  input  1  consumer accepts data.
- DaljaKanali  output  SEL_W  index of the channel that supplied Dalja.

Behaviour:
- Reset (ResetN=0 at a rising edge):
  - Dalja=0, DaljaValid=0, DaljaKanali=0.
  - Round-robin pointer ptr=0.
  - Any held word is discarded; reset has priority over all other events that cycle.
- Load condition: load_ok = !DaljaValid || DaljaReady. Loading is combinational, so a full register that is being drained accepts a new word in the same cycle.
- Grant, direct mode (Mode=0):
  - grant = S when S < CHANNELS.
  - If S >= CHANNELS (non-power-of-two CHANNELS), there is no grant and all HyrjaReady=0.
  - HyrjaReady[S] = load_ok, independent of HyrjaValid.
- Grant, round-robin mode (Mode=1):
  - grant = first k with HyrjaValid[k]=1, searching ptr, ptr+1, ..., wrapping modulo CHANNELS.
  - HyrjaReady[grant] = load_ok. If no channel is valid, all HyrjaReady=0.
  - HyrjaReady depends combinationally on HyrjaValid in this mode; producers must not make valid depend on ready.
- Transfer when HyrjaValid[grant] && HyrjaReady[grant]. On the next edge:
  - Dalja <= channel data, DaljaKanali <= grant, DaljaValid <= 1.
  - In Mode=1 only: ptr <= (grant+1) mod CHANNELS.
- No transfer and DaljaReady=1: DaljaValid <= 0. Dalja and DaljaKanali hold their last values.
- Stall (DaljaValid=1, DaljaReady=0):
  - Dalja, DaljaKanali and DaljaValid hold, and all HyrjaReady=0.
  - Output data must stay stable while DaljaValid is high and DaljaReady is low.
- Timing: latency is 1 cycle from input handshake to DaljaValid. Throughput is 1 word per cycle when DaljaReady stays high.
- Mode and S are sampled every cycle with no internal latching. A Mode change takes effect in the same cycle's grant computation.
- ptr is unchanged by transfers in Mode=0. After a switch to Mode=1, arbitration resumes from the stored ptr.
- Wrap-around: with grant=CHANNELS-1, ptr returns to 0.
- Simultaneous drain and load: the old word leaves and the new word loads on the same edge, and DaljaValid stays 1.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=24, the CPU word width and default for WIDTH.
  - MODE_DIRECT=1'b0 and MODE_RR=1'b1.
- One sub-module, rr_arbiter_n: parameter CHANNELS.
  - Inputs: request vector, ptr.
  - Outputs: grant index and grant-valid.
  - Purely combinational rotate / priority-encode / unrotate.
- ptr, the output register and the handshake logic stay in mux_nto1_reg.

Test Plan:
- Reset hold: ResetN=0 for 3 cycles with all channels valid → DaljaValid=0, Dalja=0, HyrjaReady=0; the first transfer happens in the cycle ResetN goes high, and the output appears 1 cycle later.
- Direct select, CHANNELS=4: Mode=0, S=2, Hyrja ch2=24'hABCDEF, all valid, DaljaReady=1 → next cycle Dalja=24'hABCDEF, DaljaKanali=2; HyrjaReady=4'b0100 throughout.
- Round-robin fairness: Mode=1, all 4 channels valid every cycle, data ch k=k+1, DaljaReady=1 → DaljaKanali sequence 0,1,2,3,0,1 with Dalja 1,2,3,4,1,2 on consecutive cycles.
- Back-pressure: DaljaValid=1 with Dalja=24'h000055, DaljaReady=0 for 5 cycles, inputs changing → Dalja stays 24'h000055 and HyrjaReady=0 each cycle; when DaljaReady=1, a new word loads the same cycle.
- Sparse round-robin with wrap: Mode=1, only ch3 and ch1 valid, ptr=2 → grant ch3, then ch1 (wrap), then ch3; ptr=0 after the ch3 grant.
- Mid-operation reset and invalid select: CHANNELS=3, Mode=0, S=3 → HyrjaReady=0 and no transfer; then assert ResetN=0 while DaljaValid=1 → next cycle DaljaValid=0, Dalja=0, ptr=0.
